// File: rtl/trace_dump_unit_pkg.sv
// Shared constants for the trace/dump unit: record kinds, FSM encoding and
// default widths.
package trace_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_PC_W       = 32;
  localparam int DEF_NREGS      = 32;
  localparam int DEF_REG_AW     = 5;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_CYC_W      = 32;

  localparam logic [1:0] KIND_TRACE   = 2'b00;
  localparam logic [1:0] KIND_REGDUMP = 2'b01;
  localparam logic [1:0] KIND_SUMMARY = 2'b10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DUMP    = 2'd1;
  localparam logic [1:0] ST_SUMMARY = 2'd2;

endpackage

// File: rtl/trace_dump_unit_if.sv
// Output record stream of the trace/dump unit.
// Handshake: a record transfers on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid is raised, the source holds
// out_valid and every record field unchanged until that transfer happens;
// out_ready may change freely and never depends combinationally on out_valid.
interface trace_dump_unit_if
  import trace_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CYC_W  = DEF_CYC_W
) ();

  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_kind;
  logic [CYC_W-1:0]  out_stamp;
  logic [PC_W-1:0]   out_pc;
  logic [31:0]       out_instr;
  logic [REG_AW-1:0] out_reg;
  logic              out_we;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid, out_kind, out_stamp, out_pc, out_instr, out_reg,
           out_we, out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_kind, out_stamp, out_pc, out_instr, out_reg,
           out_we, out_data,
    output out_ready
  );

endinterface

// File: rtl/trace_dump_unit_fifo.sv
// First-word-fall-through FIFO with read/write pointers and an occupancy
// count. A push while full is accepted only if a pop happens in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trace_dump_unit.sv
// Commit trace capture and register-file dump for the single-cycle MIPS core.
// Trace records queue in a FIFO; dump and summary records take priority for
// the single output register, so queued traces drain after the summary.
module trace_dump_unit
  import trace_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PC_W       = DEF_PC_W,
  parameter int NREGS      = DEF_NREGS,
  parameter int REG_AW     = DEF_REG_AW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CYC_W      = DEF_CYC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mon_valid,
  input  logic [PC_W-1:0]   mon_pc,
  input  logic [31:0]       mon_instr,
  input  logic              mon_regwrite,
  input  logic [REG_AW-1:0] mon_wreg,
  input  logic [DATA_W-1:0] mon_wdata,
  input  logic              dump_req,
  output logic [REG_AW-1:0] dbg_raddr,
  input  logic [DATA_W-1:0] dbg_rdata,
  trace_dump_unit_if.master out_bus,
  output logic              busy,
  output logic [15:0]       overflow_count,
  output logic [1:0]        fsm_state
);

  localparam int REC_W = CYC_W + PC_W + 32 + 1 + REG_AW + DATA_W;
  localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NREGS - 1);

  logic [1:0]        state;
  logic [REG_AW-1:0] idx;
  logic [CYC_W-1:0]  cycle_count;
  logic [CYC_W-1:0]  retired_count;

  logic              load;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [REC_W-1:0]  fifo_din;
  logic [REC_W-1:0]  fifo_dout;

  logic [CYC_W-1:0]  f_stamp;
  logic [PC_W-1:0]   f_pc;
  logic [31:0]       f_instr;
  logic              f_we;
  logic [REG_AW-1:0] f_wreg;
  logic [DATA_W-1:0] f_wdata;

  // Output register may take a new record when empty or being drained.
  assign load      = !out_bus.out_valid || out_bus.out_ready;
  // Traces only leave the FIFO while no dump/summary record is pending.
  assign fifo_pop  = load && (state == ST_IDLE) && !fifo_empty;
  assign fifo_push = mon_valid && (!fifo_full || fifo_pop);
  assign fifo_din  = {cycle_count, mon_pc, mon_instr, mon_regwrite, mon_wreg, mon_wdata};
  assign {f_stamp, f_pc, f_instr, f_we, f_wreg, f_wdata} = fifo_dout;

  assign dbg_raddr = (state == ST_DUMP) ? idx : '0;
  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Free-running cycle/retire counters and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count    <= '0;
      retired_count  <= '0;
      overflow_count <= '0;
    end else begin
      cycle_count <= cycle_count + 1'b1;
      if (mon_valid) retired_count <= retired_count + 1'b1;
      if (mon_valid && !fifo_push && (overflow_count != 16'hFFFF))
        overflow_count <= overflow_count + 1'b1;
    end
  end

  // Dump sequencer: walks idx on each record load, then emits one summary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dump_req) begin
            state <= ST_DUMP;
            idx   <= '0;
          end
        end
        ST_DUMP: begin
          if (load) begin
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) state <= ST_SUMMARY;
          end
        end
        ST_SUMMARY: begin
          if (load) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: dump/summary record first, else FIFO head, else idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_bus.out_valid <= 1'b0;
      out_bus.out_kind  <= '0;
      out_bus.out_stamp <= '0;
      out_bus.out_pc    <= '0;
      out_bus.out_instr <= '0;
      out_bus.out_reg   <= '0;
      out_bus.out_we    <= 1'b0;
      out_bus.out_data  <= '0;
    end else if (load) begin
      if (state == ST_DUMP) begin
        out_bus.out_valid <= 1'b1;
        out_bus.out_kind  <= KIND_REGDUMP;
        out_bus.out_stamp <= cycle_count;
        out_bus.out_pc    <= '0;
        out_bus.out_instr <= '0;
        out_bus.out_reg   <= idx;
        out_bus.out_we    <= 1'b0;
        out_bus.out_data  <= dbg_rdata;
      end else if (state == ST_SUMMARY) begin
        out_bus.out_valid <= 1'b1;
        out_bus.out_kind  <= KIND_SUMMARY;
        out_bus.out_stamp <= cycle_count;
        out_bus.out_pc    <= PC_W'(cycle_count);
        out_bus.out_instr <= 32'(retired_count);
        out_bus.out_reg   <= '0;
        out_bus.out_we    <= 1'b0;
        out_bus.out_data  <= '0;
      end else if (!fifo_empty) begin
        out_bus.out_valid <= 1'b1;
        out_bus.out_kind  <= KIND_TRACE;
        out_bus.out_stamp <= f_stamp;
        out_bus.out_pc    <= f_pc;
        out_bus.out_instr <= f_instr;
        out_bus.out_reg   <= f_wreg;
        out_bus.out_we    <= f_we;
        out_bus.out_data  <= f_wdata;
      end else begin
        out_bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trace_dump_unit.sv
// Directed bench for trace_dump_unit: single commit latency, backpressure and
// overflow, register dump, dump with concurrent commits, ignored second
// dump request, and reset in the middle of a dump.
module tb_trace_dump_unit;
  import trace_pkg::*;

  localparam int RW = 136;

  logic        clk;
  logic        reset;
  logic        mon_valid;
  logic [31:0] mon_pc;
  logic [31:0] mon_instr;
  logic        mon_regwrite;
  logic [4:0]  mon_wreg;
  logic [31:0] mon_wdata;
  logic        dump_req;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic        busy;
  logic [15:0] overflow_count;
  logic [1:0]  fsm_state;

  trace_dump_unit_if out_if ();

  trace_dump_unit dut (
    .clk            (clk),
    .reset          (reset),
    .mon_valid      (mon_valid),
    .mon_pc         (mon_pc),
    .mon_instr      (mon_instr),
    .mon_regwrite   (mon_regwrite),
    .mon_wreg       (mon_wreg),
    .mon_wdata      (mon_wdata),
    .dump_req       (dump_req),
    .dbg_raddr      (dbg_raddr),
    .dbg_rdata      (dbg_rdata),
    .out_bus        (out_if),
    .busy           (busy),
    .overflow_count (overflow_count),
    .fsm_state      (fsm_state)
  );

  // Clock and register-file model: R[i] = i*3.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always_comb dbg_rdata = 32'(dbg_raddr) * 32'd3;

  logic [RW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ret   = 0;
  int d     = 0;

  function automatic logic [RW-1:0] mk(input logic [1:0] kind, input int stamp,
                                       input logic [31:0] pc, input logic [31:0] instr,
                                       input logic [4:0] r, input logic we,
                                       input logic [31:0] data);
    return {kind, 32'(stamp), pc, instr, r, we, data};
  endfunction

  function automatic logic [RW-1:0] cur_rec();
    return {out_if.out_kind, out_if.out_stamp, out_if.out_pc, out_if.out_instr,
            out_if.out_reg, out_if.out_we, out_if.out_data};
  endfunction

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    mon_valid = 1'b0;
    cyc       = 0;
    ret       = 0;
  endtask

  // Compare a presented record against the head of the expected queue.
  task automatic observe();
    if (out_if.out_valid) begin
      if (exp_q.size() == 0) chk("extra_record", RW'(out_if.out_valid), '0);
      else chk("record", cur_rec(), exp_q.pop_front());
    end
  endtask

  task automatic drain(input int budget);
    for (int t = 0; t < budget && exp_q.size() > 0; t++) begin
      observe();
      step();
    end
    chk("drain_left", RW'(exp_q.size()), '0);
  endtask

  task automatic push_dump(input int first_stamp, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back(mk(KIND_REGDUMP, first_stamp + k, 32'd0, 32'd0, 5'(k), 1'b0, 32'(k * 3)));
  endtask

  initial begin
    reset = 1'b1; mon_valid = 1'b0; mon_pc = '0; mon_instr = '0;
    mon_regwrite = 1'b0; mon_wreg = '0; mon_wdata = '0; dump_req = 1'b0;
    out_if.out_ready = 1'b0;
    @(posedge clk);
    do_reset();

    // Reset state
    chk("rst_rec", cur_rec(), '0);
    chk("rst_valid", RW'(out_if.out_valid), '0);
    chk("rst_busy", RW'(busy), '0);
    chk("rst_ovf", RW'(overflow_count), '0);
    chk("rst_raddr", RW'(dbg_raddr), '0);
    chk("rst_state", RW'(fsm_state), RW'(ST_IDLE));

    // Single commit in cycle 3 appears in cycle 5
    out_if.out_ready = 1'b1;
    step(); step(); step();
    mon_valid = 1'b1; mon_pc = 32'd8; mon_instr = 32'h20090005;
    mon_regwrite = 1'b1; mon_wreg = 5'd9; mon_wdata = 32'd5;
    step();
    mon_valid = 1'b0;
    chk("t1_c4_valid", RW'(out_if.out_valid), '0);
    step();
    chk("t1_c5_valid", RW'(out_if.out_valid), RW'(1));
    chk("t1_rec", cur_rec(), mk(KIND_TRACE, 3, 32'd8, 32'h20090005, 5'd9, 1'b1, 32'd5));
    step();
    chk("t1_c6_valid", RW'(out_if.out_valid), '0);
    chk("t1_ovf", RW'(overflow_count), '0);

    // Backpressure: 12 commits, 1 held + 8 queued + 3 dropped
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      mon_valid = 1'b1; mon_pc = 32'h100 + 32'(4 * i); mon_instr = 32'h1000 + 32'(i);
      mon_regwrite = i[0]; mon_wreg = 5'(i); mon_wdata = 32'hA000 + 32'(i);
      if (i < 9) exp_q.push_back(mk(KIND_TRACE, cyc, mon_pc, mon_instr, mon_wreg, mon_regwrite, mon_wdata));
      step();
    end
    mon_valid = 1'b0;
    step(); step();
    chk("t2_ovf", RW'(overflow_count), RW'(3));
    chk("t2_hold_valid", RW'(out_if.out_valid), RW'(1));
    chk("t2_hold_rec", cur_rec(), exp_q[0]);
    step();
    chk("t2_hold_stable", cur_rec(), exp_q[0]);
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("t2_rec", cur_rec(), exp_q.pop_front());
      step();
    end
    chk("t2_end_valid", RW'(out_if.out_valid), '0);

    // Register dump from a fresh reset
    do_reset();
    d = cyc;
    push_dump(d + 1, 32);
    exp_q.push_back(mk(KIND_SUMMARY, d + 33, 32'(d + 33), 32'(ret), 5'd0, 1'b0, 32'd0));
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    chk("t3_busy", RW'(busy), RW'(1));
    drain(60);
    step();
    chk("t3_busy_end", RW'(busy), '0);
    chk("t3_valid_end", RW'(out_if.out_valid), '0);

    // Dump with 4 concurrent commits and an ignored second dump_req
    d = cyc;
    push_dump(d + 1, 32);
    exp_q.push_back(mk(KIND_SUMMARY, d + 33, 32'(d + 33), 32'(ret + 4), 5'd0, 1'b0, 32'd0));
    for (int t = 3; t <= 18; t += 5)
      exp_q.push_back(mk(KIND_TRACE, d + t, 32'h400 + 32'(t), 32'hC000 + 32'(t), 5'(t), 1'b1, 32'h77 + 32'(t)));
    for (int t = 0; t < 80 && exp_q.size() > 0; t++) begin
      dump_req  = (t == 0 || t == 10);
      mon_valid = (t == 3 || t == 8 || t == 13 || t == 18);
      mon_pc = 32'h400 + 32'(t); mon_instr = 32'hC000 + 32'(t);
      mon_regwrite = 1'b1; mon_wreg = 5'(t); mon_wdata = 32'h77 + 32'(t);
      if (t == 10) begin
        chk("t4_raddr", RW'(dbg_raddr), RW'(9));
        chk("t4_state", RW'(fsm_state), RW'(ST_DUMP));
      end
      observe();
      step();
    end
    dump_req = 1'b0; mon_valid = 1'b0;
    ret += 4;
    chk("t4_left", RW'(exp_q.size()), '0);
    chk("t4_ovf", RW'(overflow_count), '0);
    step(); step();
    chk("t4_no_second_dump", RW'(out_if.out_valid), '0);
    chk("t4_idle", RW'(fsm_state), RW'(ST_IDLE));

    // Reset after 10 regdump records, with a commit during reset
    d = cyc;
    push_dump(d + 1, 10);
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    drain(20);
    reset = 1'b1; mon_valid = 1'b1;
    step();
    reset = 1'b0; mon_valid = 1'b0; cyc = 0; ret = 0;
    chk("t6_rec", cur_rec(), '0);
    chk("t6_busy", RW'(busy), '0);
    chk("t6_ovf", RW'(overflow_count), '0);
    chk("t6_state", RW'(fsm_state), RW'(ST_IDLE));
    chk("t6_raddr", RW'(dbg_raddr), '0);
    step(); step();
    chk("t6_fifo_empty", RW'(out_if.out_valid), '0);
    d = cyc;
    push_dump(d + 1, 32);
    exp_q.push_back(mk(KIND_SUMMARY, d + 33, 32'(d + 33), 32'(ret), 5'd0, 1'b0, 32'd0));
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    drain(60);
    step();
    chk("t6_busy_end", RW'(busy), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trace_dump_unit.md
Name: trace_dump_unit

Overview:
- Synthesizable, parametrised debug/trace block for the single-cycle MIPS core.
- Captures every committed instruction (PC, instruction, write-back register and data) into a trace FIFO, stamped with a free-running cycle counter.
- On request, walks the register file through a dedicated read port.
- Emits all records on one valid/ready stream for an off-chip logger or bench consumer.

Parameters:
- DATA_W, 32: register/write-back data width
- PC_W, 32: program counter width
- NREGS, 32: number of architectural registers dumped
- REG_AW, 5: register index width, clog2(NREGS)
- FIFO_DEPTH, 8: trace FIFO entries, power of two, ≥2
- CYC_W, 32: cycle and retired-instruction counter width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mon_valid  in  1  instruction commits this cycle
- mon_pc  in  PC_W  PC of committing instruction
- mon_instr  in  32  instruction word
- mon_regwrite  in  1  RegWrite of committing instruction
- mon_wreg  in  REG_AW  destination register
- mon_wdata  in  DATA_W  write-back data
- dump_req  in  1  start register dump (level sampled in IDLE)
- dbg_raddr  out  REG_AW  register file debug read address
- dbg_rdata  in  DATA_W  combinational read data for dbg_raddr
- out_valid  out  1  record valid
- out_ready  in  1  consumer accepts record
- out_kind  out  2  00 trace, 01 regdump, 10 summary
- out_stamp  out  CYC_W  cycle count at capture
- out_pc  out  PC_W  trace: PC; summary: cycle_count
- out_instr  out  32  trace: instruction; summary: retired_count
- out_reg  out  REG_AW  trace: wreg; regdump: index
- out_we  out  1  trace: regwrite; otherwise 0
- out_data  out  DATA_W  trace: wdata; regdump: register value
- busy  out  1  dump or summary in progress
- overflow_count  out  16  dropped trace records, saturating

Behaviour:
- Reset:
  - All outputs 0, state IDLE, FIFO empty.
  - cycle_count = 0, retired_count = 0, dbg_raddr = 0.
- Counters:
  - cycle_count increments every non-reset cycle and wraps.
  - retired_count increments on mon_valid and wraps.
  - out_stamp of a trace record = cycle_count in the cycle mon_valid was high.
- Trace FIFO:
  - Push on mon_valid when not full, or when full and a pop occurs in the same cycle.
  - Otherwise drop the record and increment overflow_count (saturate at 0xFFFF).
  - Capture continues during dump and summary.
- Output register:
  - Single registered stage, loaded when !out_valid || out_ready.
  - Fields must remain stable while out_valid && !out_ready.
  - Load source by priority: DUMP/SUMMARY state record, else FIFO head (pop), else out_valid <= 0.
- Latency:
  - A commit in cycle N with an idle, empty path appears as out_valid in cycle N+2.
  - With out_ready held high, throughput is 1 record/cycle.
- FSM states: IDLE, DUMP, SUMMARY.
  - IDLE: dump_req = 1 → DUMP, idx = 0. dbg_raddr = 0.
  - DUMP: dbg_raddr = idx. On load, capture {kind 01, stamp, reg = idx, data = dbg_rdata}. idx++. If idx = NREGS-1 at load → SUMMARY.
  - SUMMARY: on load, capture {kind 10, out_pc = cycle_count, out_instr = retired_count} → IDLE.
  - busy = 1 in DUMP and SUMMARY.
  - dump_req outside IDLE is ignored.
- Trace records queued before or during a dump are emitted after SUMMARY.
- Register 0 is dumped as returned by dbg_rdata; no special case.
- Reset mid-dump:
  - Abort to IDLE.
  - Flush FIFO and output register.
  - Clear counters and overflow_count.
- mon_valid together with reset: ignored.

Decomposition:
- Package trace_pkg:
  - Record-kind constants KIND_TRACE = 2'b00, KIND_REGDUMP = 2'b01, KIND_SUMMARY = 2'b10.
  - FSM state encoding.
  - Default widths.
- Sub-module trace_fifo:
  - Synchronous FWFT FIFO, parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Pointer-plus-count implementation.
  - Instantiated once, carrying {stamp, pc, instr, we, wreg, wdata}.

Test Plan:
- Single commit: reset, then mon_valid in cycle 3 with pc = 8, instr = 0x20090005, wreg = 9, wdata = 5, regwrite = 1, out_ready = 1. Expect: one trace record in cycle 5 with stamp = 3; overflow_count = 0.
- Backpressure/overflow: out_ready = 0, FIFO_DEPTH = 8, 12 consecutive commits. Expect: 1 record held in the output register, 8 in the FIFO, overflow_count = 3. Releasing out_ready emits the 9 records in order with unchanged fields.
- Register dump: preload R[i] = i*3, dump_req pulse, out_ready = 1. Expect: 32 regdump records, indices 0..31 with data 0..93, then one summary carrying correct counters. busy falls after the summary is accepted.
- Dump with concurrent commits: 4 commits during the dump. Expect: all 4 trace records emitted after the summary, overflow_count = 0.
- dump_req while busy: second pulse mid-dump. Expect: exactly 32 regdump records plus 1 summary, no second dump.
- Reset mid-dump: reset asserted after 10 regdump records. Expect: next cycle out_valid = 0, busy = 0, counters 0, FIFO empty. A new dump_req then starts again at index 0.
